// File: rtl/scan_mem_reg_mux_if.sv
// rtl/scan_mem_reg_mux_if.sv - scan request/response bus between the scan controller and the completion stage
interface scan_mem_reg_mux_if;
    logic        scan_wen;
    logic        scan_ren;
    logic [11:0] scan_addr;
    logic [31:0] scan_wdata;
    logic [31:0] scan_rdata;
    logic        scan_ready;

    modport master (
        output scan_wen,
        output scan_ren,
        output scan_addr,
        output scan_wdata,
        input  scan_rdata,
        input  scan_ready
    );

    modport slave (
        input  scan_wen,
        input  scan_ren,
        input  scan_addr,
        input  scan_wdata,
        output scan_rdata,
        output scan_ready
    );
endinterface

// File: rtl/scan_mem_reg_mux.sv
// rtl/scan_mem_reg_mux.sv - scan access completion stage: SRAM/register-file decode and response sequencing
module scan_mem_reg_mux #(
    parameter int MEM_LAT     = 2,
    parameter int REG_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    scan_mem_reg_mux_if.slave        scan,
    output logic                     mem_cs,
    output logic                     mem_we,
    output logic [10:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    output logic                     reg_wen,
    output logic                     reg_ren,
    output logic [7:0]               reg_addr,
    output logic [31:0]              reg_wdata,
    input  logic [31:0]              reg_rdata,
    input  logic                     reg_ack,
    output logic                     busy,
    output logic                     err,
    input  logic                     err_clr
);
    localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        MEM_ACC,
        MEM_WAIT,
        REG_WAIT,
        RESP
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        resp_hold, resp_hold_n;

    logic        op_wr;
    logic [10:0] mem_addr_q;
    logic [7:0]  reg_addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req;
    logic        hit_mem;
    logic        hit_reg;
    logic        accept;
    logic        cap_mem;
    logic        cap_reg;
    logic        timeout;
    logic        load_bad;
    logic        err_set;

    assign req     = scan.scan_wen | scan.scan_ren;
    assign hit_mem = ~scan.scan_addr[11];
    assign hit_reg = (scan.scan_addr[11:8] == 4'b1000);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            resp_hold <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            resp_hold <= resp_hold_n;
        end
    end

    // Unmapped requests sit one extra cycle in RESP (resp_hold) so they
    // report at T+2, the same as the fastest mapped access.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        resp_hold_n = resp_hold;
        accept      = 1'b0;
        cap_mem     = 1'b0;
        cap_reg     = 1'b0;
        timeout     = 1'b0;
        load_bad    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    cnt_n  = '0;
                    if (hit_mem) begin
                        state_n = MEM_ACC;
                    end else if (hit_reg) begin
                        state_n = REG_WAIT;
                    end else begin
                        state_n     = RESP;
                        resp_hold_n = 1'b1;
                    end
                end
            end
            MEM_ACC: begin
                if (op_wr) begin
                    state_n = RESP;
                end else begin
                    state_n = MEM_WAIT;
                    cnt_n   = 8'(MEM_LAT - 1);
                end
            end
            MEM_WAIT: begin
                if (cnt == 8'd0) begin
                    cap_mem = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            REG_WAIT: begin
                if (reg_ack) begin
                    cap_reg = 1'b1;
                    state_n = RESP;
                end else if (cnt == 8'(REG_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            RESP: begin
                if (resp_hold) begin
                    resp_hold_n = 1'b0;
                    load_bad    = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign err_set = (req & (state != IDLE))
                   | (accept & scan.scan_wen & scan.scan_ren)
                   | (accept & ~hit_mem & ~hit_reg)
                   | timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr      <= 1'b0;
            mem_addr_q <= '0;
            reg_addr_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                op_wr      <= scan.scan_wen;
                mem_addr_q <= scan.scan_addr[10:0];
                reg_addr_q <= scan.scan_addr[7:0];
                wdata_q    <= scan.scan_wdata;
            end
            if (cap_mem) begin
                rdata_q <= mem_rdata;
            end else if (cap_reg && !op_wr) begin
                rdata_q <= reg_rdata;
            end else if ((timeout || load_bad) && !op_wr) begin
                rdata_q <= BAD_DATA;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign mem_cs          = (state == MEM_ACC);
    assign mem_we          = mem_cs & op_wr;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = wdata_q;
    assign reg_wen         = (state == REG_WAIT) & op_wr;
    assign reg_ren         = (state == REG_WAIT) & ~op_wr;
    assign reg_addr        = reg_addr_q;
    assign reg_wdata       = wdata_q;
    assign busy            = (state != IDLE);
    assign err             = err_q;
    assign scan.scan_rdata = rdata_q;
    assign scan.scan_ready = (state == RESP) & ~resp_hold;
endmodule

// File: tb/tb_scan_mem_reg_mux.sv
// tb/tb_scan_mem_reg_mux.sv - self-checking bench for scan_mem_reg_mux
module tb_scan_mem_reg_mux;
    localparam int MEM_LAT     = 2;
    localparam int REG_TIMEOUT = 15;
    localparam int MAXC        = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_cs, mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        reg_wen, reg_ren;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        reg_ack;
    logic        busy, err, err_clr;

    scan_mem_reg_mux_if sif ();

    scan_mem_reg_mux #(.MEM_LAT(MEM_LAT), .REG_TIMEOUT(REG_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .scan      (sif),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .reg_wen   (reg_wen),
        .reg_ren   (reg_ren),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Expected behaviour per cycle, filled in when a request is issued.
    logic        exp_busy [MAXC];
    logic        exp_ready [MAXC];
    logic        exp_mem_cs [MAXC];
    logic        exp_mem_we [MAXC];
    logic [10:0] exp_mem_addr [MAXC];
    logic [31:0] exp_mem_wdata [MAXC];
    logic        exp_reg_wen [MAXC];
    logic        exp_reg_ren [MAXC];
    logic [7:0]  exp_reg_addr [MAXC];
    logic [31:0] exp_reg_wdata [MAXC];
    logic        exp_err [MAXC];
    logic [31:0] exp_rdata [MAXC];
    logic        set_vis [MAXC];
    logic        rd_upd [MAXC];
    logic [31:0] rd_val [MAXC];
    logic        mrd_v [MAXC];
    logic [31:0] mrd_d [MAXC];
    logic        ack_at [MAXC];
    logic [31:0] ack_d [MAXC];
    logic [31:0] mdl_mem [2048];

    int          cyc = 0;
    int          vectors = 0;
    int          fails = 0;
    logic        chk_on = 1'b0;
    logic        stray_en = 1'b0;

    logic        nxt_valid = 1'b0, nxt_wen = 1'b0, nxt_ren = 1'b0;
    logic        nxt_rst = 1'b0, nxt_clr = 1'b0;
    logic [11:0] nxt_addr = '0;
    logic [31:0] nxt_wdata = '0, nxt_rdval = '0;
    int          nxt_ack = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_future(input int from);
        for (int c = from; c < MAXC; c++) begin
            exp_busy[c] = 0; exp_ready[c] = 0; exp_mem_cs[c] = 0; exp_mem_we[c] = 0;
            exp_mem_addr[c] = '0; exp_mem_wdata[c] = '0; exp_reg_wen[c] = 0; exp_reg_ren[c] = 0;
            exp_reg_addr[c] = '0; exp_reg_wdata[c] = '0; exp_err[c] = 0; exp_rdata[c] = '0;
            set_vis[c] = 0; rd_upd[c] = 0; rd_val[c] = '0; mrd_v[c] = 0; mrd_d[c] = '0;
            ack_at[c] = 0; ack_d[c] = '0;
        end
    endtask

    task automatic schedule(input int t);
        logic        wr;
        logic [11:0] a;
        int          r;
        int          last;
        wr = nxt_wen;
        a  = nxt_addr;
        if (nxt_wen && nxt_ren) set_vis[t+1] = 1;
        if (a[11] == 1'b0) begin
            exp_mem_cs[t+1]    = 1;
            exp_mem_we[t+1]    = wr;
            exp_mem_addr[t+1]  = a[10:0];
            exp_mem_wdata[t+1] = nxt_wdata;
            if (wr) begin
                mdl_mem[a[10:0]] = nxt_wdata;
                r = t + 2;
            end else begin
                r = t + 2 + MEM_LAT;
                mrd_v[t+1+MEM_LAT] = 1;
                mrd_d[t+1+MEM_LAT] = mdl_mem[a[10:0]];
                rd_upd[r] = 1;
                rd_val[r] = mdl_mem[a[10:0]];
            end
        end else if (a[11:8] == 4'h8) begin
            if (nxt_ack == 0 || nxt_ack > REG_TIMEOUT) begin
                last = t + REG_TIMEOUT;
                set_vis[last+1] = 1;
                if (!wr) begin rd_upd[last+1] = 1; rd_val[last+1] = 32'hDEAD_BEEF; end
            end else begin
                last = t + nxt_ack;
                ack_at[last] = 1;
                ack_d[last]  = nxt_rdval;
                if (!wr) begin rd_upd[last+1] = 1; rd_val[last+1] = nxt_rdval; end
            end
            for (int c = t + 1; c <= last; c++) begin
                exp_reg_wen[c]   = wr;
                exp_reg_ren[c]   = !wr;
                exp_reg_addr[c]  = a[7:0];
                exp_reg_wdata[c] = nxt_wdata;
            end
            r = last + 1;
        end else begin
            set_vis[t+1] = 1;
            r = t + 2;
            if (!wr) begin rd_upd[r] = 1; rd_val[r] = 32'hDEAD_BEEF; end
        end
        for (int c = t + 1; c <= r; c++) exp_busy[c] = 1;
        exp_ready[r] = 1;
    endtask

    // Drive one cycle of stimulus at posedge+1, advance the model, move to the next cycle.
    task automatic run_cycle();
        int t;
        t = cyc;
        mem_rdata = mrd_v[t] ? mrd_d[t] : $urandom();
        if (ack_at[t]) begin
            reg_ack   = 1'b1;
            reg_rdata = ack_d[t];
        end else begin
            reg_ack   = stray_en && !(exp_reg_wen[t] || exp_reg_ren[t]) && ($urandom_range(0, 7) == 0);
            reg_rdata = $urandom();
        end
        rst            = nxt_rst;
        err_clr        = nxt_clr;
        sif.scan_wen   = nxt_valid & nxt_wen;
        sif.scan_ren   = nxt_valid & nxt_ren;
        sif.scan_addr  = nxt_addr;
        sif.scan_wdata = nxt_wdata;
        if (nxt_rst) begin
            clear_future(t + 1);
        end else begin
            if (nxt_valid && (nxt_wen || nxt_ren)) begin
                if (exp_busy[t]) set_vis[t+1] = 1;
                else schedule(t);
            end
            exp_err[t+1]   = set_vis[t+1] ? 1'b1 : (nxt_clr ? 1'b0 : exp_err[t]);
            exp_rdata[t+1] = rd_upd[t+1] ? rd_val[t+1] : exp_rdata[t];
        end
        @(posedge clk);
        #1;
        cyc++;
        nxt_valid = 0; nxt_rst = 0; nxt_clr = 0; nxt_wen = 0; nxt_ren = 0; nxt_ack = 0;
    endtask

    task automatic req(input logic w, input logic r, input logic [11:0] a, input logic [31:0] d,
                       input int ack, input logic [31:0] rv);
        nxt_valid = 1; nxt_wen = w; nxt_ren = r; nxt_addr = a; nxt_wdata = d;
        nxt_ack = ack; nxt_rdval = rv;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("busy", busy, exp_busy[cyc]);
            check("scan_ready", sif.scan_ready, exp_ready[cyc]);
            check("scan_rdata", sif.scan_rdata, exp_rdata[cyc]);
            check("err", err, exp_err[cyc]);
            check("mem_cs", mem_cs, exp_mem_cs[cyc]);
            check("reg_wen", reg_wen, exp_reg_wen[cyc]);
            check("reg_ren", reg_ren, exp_reg_ren[cyc]);
            if (exp_mem_cs[cyc]) begin
                check("mem_we", mem_we, exp_mem_we[cyc]);
                check("mem_addr", mem_addr, exp_mem_addr[cyc]);
                if (exp_mem_we[cyc]) check("mem_wdata", mem_wdata, exp_mem_wdata[cyc]);
            end
            if (exp_reg_wen[cyc] || exp_reg_ren[cyc]) begin
                check("reg_addr", reg_addr, exp_reg_addr[cyc]);
                if (exp_reg_wen[cyc]) check("reg_wdata", reg_wdata, exp_reg_wdata[cyc]);
            end
        end
    end

    initial begin
        int k;
        logic [11:0] a;
        clear_future(0);
        for (int i = 0; i < 2048; i++) mdl_mem[i] = $urandom();
        rst = 1; err_clr = 0; reg_ack = 0; reg_rdata = '0; mem_rdata = '0;
        sif.scan_wen = 0; sif.scan_ren = 0; sif.scan_addr = '0; sif.scan_wdata = '0;
        @(posedge clk);
        #1;
        nxt_rst = 1; run_cycle();
        nxt_rst = 1; run_cycle();
        chk_on = 1;
        check("reset_busy", busy, 1'b0);
        check("reset_rdata", sif.scan_rdata, 32'h0);
        check("reset_err", err, 1'b0);
        run_cycle();

        // SRAM write 0x005
        req(1, 0, 12'h005, 32'h1234_5678, 0, 0); run_cycle();
        check("wr_mem_cs", mem_cs, 1'b1);
        check("wr_mem_we", mem_we, 1'b1);
        check("wr_mem_addr", mem_addr, 11'h005);
        run_cycle();
        check("wr_ready", sif.scan_ready, 1'b1);
        check("wr_rdata", sif.scan_rdata, 32'h0);
        run_cycle();

        // SRAM read 0x005
        req(0, 1, 12'h005, 0, 0, 0); run_cycle();
        check("rd_mem_cs", mem_cs, 1'b1);
        run_cycle(); run_cycle(); run_cycle();
        check("rd_ready", sif.scan_ready, 1'b1);
        check("rd_rdata", sif.scan_rdata, 32'h1234_5678);
        run_cycle();

        // register read 0x8A3, ack after 3 cycles
        req(0, 1, 12'h8A3, 0, 3, 32'hCAFE_0001); run_cycle();
        check("reg_addr_lit", reg_addr, 8'hA3);
        check("reg_ren_lit", reg_ren, 1'b1);
        run_cycle(); run_cycle(); run_cycle();
        check("reg_rd_ready", sif.scan_ready, 1'b1);
        check("reg_rd_rdata", sif.scan_rdata, 32'hCAFE_0001);
        run_cycle();

        // register write with no ack: timeout
        req(1, 0, 12'h810, 32'h0BAD_F00D, 0, 0); run_cycle();
        repeat (REG_TIMEOUT) run_cycle();
        check("to_ready", sif.scan_ready, 1'b1);
        check("to_err", err, 1'b1);
        nxt_clr = 1; run_cycle();
        check("to_err_clr", err, 1'b0);

        // unmapped read, plus a request dropped while busy
        req(0, 1, 12'h900, 0, 0, 0); run_cycle();
        req(0, 1, 12'h001, 0, 0, 0); run_cycle();
        check("unm_ready", sif.scan_ready, 1'b1);
        check("unm_rdata", sif.scan_rdata, 32'hDEAD_BEEF);
        check("unm_err", err, 1'b1);
        run_cycle();
        check("unm_no_extra_ready", sif.scan_ready, 1'b0);
        nxt_clr = 1; run_cycle();

        // reset during MEM_WAIT, then a clean read
        req(0, 1, 12'h005, 0, 0, 0); run_cycle();
        run_cycle();
        nxt_rst = 1; run_cycle();
        check("rst_busy", busy, 1'b0);
        check("rst_rdata", sif.scan_rdata, 32'h0);
        run_cycle(); run_cycle();
        req(0, 1, 12'h005, 0, 0, 0); run_cycle();
        run_cycle(); run_cycle(); run_cycle();
        check("post_rst_rdata", sif.scan_rdata, 32'h1234_5678);
        run_cycle();

        // randomized traffic
        stray_en = 1;
        while (cyc < 3400) begin
            if ($urandom_range(0, 299) == 0) begin
                nxt_rst = 1;
            end else if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 9);
                if (k <= 3)      a = 12'($urandom_range(0, 31));
                else if (k <= 6) a = {4'h8, 8'($urandom())};
                else if (k == 7) a = {4'($urandom_range(9, 15)), 8'($urandom())};
                else             a = 12'($urandom());
                k = $urandom_range(0, 9);
                req(k <= 3 || k == 9, k >= 4, a, $urandom(),
                    ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 5), $urandom());
            end
            nxt_clr = ($urandom_range(0, 5) == 0);
            run_cycle();
        end
        stray_en = 0;
        repeat (REG_TIMEOUT + MEM_LAT + 4) run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/scan_mem_reg_mux.md
# scan_mem_reg_mux

Downstream completion stage for scan-chain accesses. Accepts one-cycle request pulses (`scan_wen`/`scan_ren`/`scan_addr`/`scan_wdata`) from the scan read/write controller and decodes `scan_addr` to an on-chip SRAM port or the register-file port. It sequences the target's latency or acknowledge and returns `scan_rdata` with a one-cycle `scan_ready` pulse for every completed request, reads and writes alike. It also flags unmapped, timed-out and overlapping requests.

## Interface

Parameters:
- `MEM_LAT`, 2: SRAM read latency in cycles from the `mem_cs` cycle to `mem_rdata` valid; legal range 1..4.
- `REG_TIMEOUT`, 15: maximum cycles a register strobe is held waiting for `reg_ack`; legal range 1..255.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `scan_wen`  in  1  write request pulse.
- `scan_ren`  in  1  read request pulse.
- `scan_addr`  in  12  request address.
- `scan_wdata`  in  32  write data.
- `scan_rdata`  out  32  read data; holds the last read result.
- `scan_ready`  out  1  one-cycle completion pulse.
- `mem_cs`  out  1  SRAM select, one cycle per access.
- `mem_we`  out  1  SRAM write enable; qualified by `mem_cs`.
- `mem_addr`  out  11  SRAM word address.
- `mem_wdata`  out  32  SRAM write data.
- `mem_rdata`  in  32  SRAM read data.
- `reg_wen`  out  1  register write strobe, held until acknowledged.
- `reg_ren`  out  1  register read strobe, held until acknowledged.
- `reg_addr`  out  8  register index.
- `reg_wdata`  out  32  register write data.
- `reg_rdata`  in  32  register read data; valid in the `reg_ack` cycle.
- `reg_ack`  in  1  register access complete.
- `busy`  out  1  high whenever state is not IDLE.
- `err`  out  1  sticky error flag.
- `err_clr`  in  1  clears `err`.

## Operation

- Decode, applied to a request accepted in IDLE:
  - `scan_addr[11]=0`: SRAM, `mem_addr = scan_addr[10:0]`.
  - `scan_addr[11:8]=4'b1000`: register file, `reg_addr = scan_addr[7:0]`.
  - Any other value: unmapped.
- A request is `scan_wen | scan_ren`. If both are high, the access is treated as a write, `scan_rdata` is unchanged and `err` is set.
- FSM states: IDLE, MEM_ACC, MEM_WAIT, REG_WAIT, RESP.
  - IDLE + SRAM request -> MEM_ACC. IDLE + register request -> REG_WAIT. IDLE + unmapped request -> RESP.
  - MEM_ACC: drives `mem_cs=1` for exactly one cycle. Write -> RESP. Read -> MEM_WAIT.
  - MEM_WAIT: a counter runs `MEM_LAT` cycles; `mem_rdata` is captured into `scan_rdata` in the final cycle -> RESP.
  - REG_WAIT: strobe and address/data are held. On `reg_ack=1`, the strobe drops next cycle, read data is captured from `reg_rdata` -> RESP. After `REG_TIMEOUT` cycles with no ack: strobe drops, reads load `scan_rdata=32'hDEAD_BEEF`, `err` is set -> RESP.
  - RESP: `scan_ready=1` for one cycle -> IDLE.
- Unmapped request: reads load `scan_rdata=32'hDEAD_BEEF`; `err` is set.
- A request arriving while `busy=1` is dropped: no target access, no `scan_ready`, `err` is set.
- `err` clears on `err_clr`. If `err_clr` and a new error occur in the same cycle, the set wins.
- Writes never modify `scan_rdata`.

## Timing

- Reset values: all outputs 0, `scan_rdata=0`, state IDLE. Reset mid-transaction abandons it with no `scan_ready`, and strobes drop in the cycle after reset is sampled.
- The request is sampled at the edge ending cycle T. Target outputs are registered.
- SRAM write: `mem_cs=mem_we=1` in T+1; `scan_ready` in T+2.
- SRAM read: `mem_cs=1, mem_we=0` in T+1; `mem_rdata` is sampled in cycle T+1+`MEM_LAT`; `scan_ready` and the new `scan_rdata` appear in T+2+`MEM_LAT`.
- Register access: strobe high from T+1 through the ack cycle A inclusive; `scan_ready` and `scan_rdata` in A+1. `reg_ack` sampled in the same cycle the strobe first rises completes in one cycle.
- Timeout: strobe is held T+1..T+`REG_TIMEOUT`; `scan_ready` in T+`REG_TIMEOUT`+1.
- Unmapped: `scan_ready` in T+2.
- `busy` is high from T+1 through the `scan_ready` cycle inclusive. The next request is accepted in the cycle after `scan_ready`.
- `reg_ack` while not in REG_WAIT is ignored.

## Test plan

- Reset, then SRAM write to addr 0x005 with data 0x12345678: `mem_cs=mem_we=1`, `mem_addr=0x005` in T+1; `scan_ready` in T+2; `scan_rdata` stays 0.
- SRAM read of 0x005 with `MEM_LAT=2`, model returns 0x12345678: `scan_ready` and `scan_rdata=0x12345678` in T+4; `mem_cs` high exactly one cycle.
- Register read of 0x8A3 with `reg_ack` after 3 cycles and `reg_rdata=0xCAFE0001`: `reg_addr=0xA3`, `reg_ren` high for 3 cycles, then `scan_ready` with `scan_rdata=0xCAFE0001`.
- Register write with `reg_ack` never asserted: `reg_wen` high for 15 cycles, `scan_ready` at T+16, `err=1`; `err_clr` pulse returns `err` to 0.
- Read of unmapped 0x900: `scan_ready` at T+2, `scan_rdata=0xDEADBEEF`, `err=1`. A second request issued while `busy=1` is dropped with no extra `scan_ready`.
- Assert `rst` during MEM_WAIT: no `scan_ready`, all outputs 0 next cycle, and a subsequent SRAM read completes normally.
